fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the processor's decode/execute path (main). Holds the PC and an internal instruction memory, and issues sequential synchronous reads. Buffers fetched words in a 2-entry queue and delivers them to decode over a valid/ready handshake. Supports PC redirect (flush), a start pulse, and halt-on-opcode.

Parameters:
PC_W, 8, PC and instruction-memory address width
INST_W, 32, instruction width
IMEM_DEPTH, 256, instruction-memory words (2**PC_W)
HALT_OP, 8'hFF, opcode value that stops fetching

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begin fetching from start_pc
start_pc  in  PC_W  initial PC, sampled when start=1
load_en  in  1  instruction-memory write enable (program load)
load_addr  in  PC_W  write address
load_data  in  INST_W  write data
redirect_valid  in  1  flush and restart at redirect_pc
redirect_pc  in  PC_W  new PC
inst_ready  in  1  decode accepts inst this cycle
inst_valid  out  1  inst/inst_pc valid
inst  out  INST_W  instruction: [31:24] opcode, [23:16] insa, [15:8] insb, [7:0] write-back dest
inst_pc  out  PC_W  address inst was fetched from
halted  out  1  high in HALT state

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=0, queue empty, in-flight=0, inst_valid=0, inst=0, inst_pc=0, halted=0. Memory contents are not reset.
- Memory: one write port (load_en) and one synchronous read port with 1-cycle latency.
  - A write and a read to the same address in the same cycle returns the old data.
  - Loading during FETCH is legal; ordering is the loader's responsibility.
- States:
  - IDLE: no reads. start -> FETCH with pc=start_pc.
  - FETCH: issues a read at pc when (queue count + in-flight) < 2, then pc <= pc+1.
    - pc wraps modulo 2**PC_W (8'hFF -> 8'h00).
  - HALT: no reads; halted=1. start -> FETCH (pc=start_pc). redirect_valid -> FETCH (pc=redirect_pc).
- FETCH -> HALT: when a returning word has opcode==HALT_OP.
  - That word is enqueued and delivered normally.
  - The read issued in the same cycle (in flight) is discarded on return.
- Queue: 2-entry FIFO; the head drives inst/inst_pc; inst_valid = queue not empty.
  - Pop on inst_valid && inst_ready.
  - Simultaneous pop and push allowed when full or non-empty.
  - Never overflows, because issue counts the in-flight read.
- Handshake: inst/inst_pc stay stable while inst_valid=1 and inst_ready=0. First instruction is visible 2 cycles after start (issue cycle + read latency).
- redirect_valid (any state except IDLE):
  - Same cycle: queue cleared and in-flight read marked stale.
  - Next cycle: inst_valid=0, pc=redirect_pc, and a read may issue immediately.
  - Stale data is dropped.
  - redirect wins over start, pop, and halt detection in the same cycle.
- start in FETCH: acts as redirect to start_pc.
- reset asserted mid-operation: immediate return to reset values. Queued and in-flight words are lost.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds output port fetch_count (32-bit).
  - Increments on each handshake (inst_valid && inst_ready); saturates at 32'hFFFFFFFF.
  - Reset to 0 by reset; not cleared by redirect/start.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package fetch_pkg: PC_W, INST_W, HALT_OP, field-slice constants (OP_MSB=31, OP_LSB=24, A_MSB=23, ...), state encoding (IDLE=2'd0, FETCH=2'd1, HALT=2'd2).
- One natural sub-module: fetch_buf, the 2-entry FIFO with push/pop/flush and count output.
- Memory is inline in fetch_unit.

Test Plan:
- Load mem[0..3]={32'h01020304,32'h02050600,32'h03000000,32'hFF000000}; start with start_pc=0; inst_ready=1 -> inst_valid from cycle 2; inst_pc 0,1,2,3 in consecutive cycles; halted=1 after word 3 delivered; no inst_pc=4 ever delivered.
- Same program with inst_ready=0 for 5 cycles after first valid -> inst=32'h01020304 held stable; at most 2 entries queued; on release, words delivered in order with no loss or duplication.
- Redirect_valid with redirect_pc=8'h10 while queue holds pc 1,2 -> next cycle inst_valid=0; next delivered inst_pc=8'h10; pc 1,2 never delivered.
- start_pc=8'hFE, mem[FE],mem[FF],mem[00] non-halt -> inst_pc sequence FE,FF,00 (wrap).
- Assert reset low mid-stream while inst_valid=1 -> inst_valid, inst, inst_pc, halted all 0 immediately (before next clk edge); no output until next start.
- With FETCH_PERF_CNT_EN, deliver 4 instructions with a stall in between -> fetch_count=4; after redirect, count unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: widths,
// instruction field positions, halt opcode and FSM state encoding.
package fetch_pkg;
  localparam int PC_W       = 8;
  localparam int INST_W     = 32;
  localparam int IMEM_DEPTH = 2 ** PC_W;
  localparam logic [7:0] HALT_OP = 8'hFF;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 24;
  localparam int A_MSB  = 23;
  localparam int A_LSB  = 16;
  localparam int B_MSB  = 15;
  localparam int B_LSB  = 8;
  localparam int D_MSB  = 7;
  localparam int D_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

  function automatic logic [7:0] opcode_of(input logic [INST_W-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction
endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO between the instruction memory and decode.
// Flush empties it in one cycle and takes priority over push/pop.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [INST_W-1:0] push_inst,
  input  logic [PC_W-1:0]   push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic [INST_W-1:0] head_inst,
  output logic [PC_W-1:0]   head_pc
);
  logic [INST_W-1:0] inst_q [2];
  logic [PC_W-1:0]   pc_q   [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      inst_q[wr_ptr] <= push_inst;
      pc_q[wr_ptr]   <= push_pc;
    end
  end

  assign head_inst = inst_q[rd_ptr];
  assign head_pc   = pc_q[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, inline instruction memory, 2-entry queue to decode.
// Optional FETCH_PERF_CNT_EN adds a saturating 32-bit delivered-instruction counter.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W-1:0]   start_pc,
  input  logic              load_en,
  input  logic [PC_W-1:0]   load_addr,
  input  logic [INST_W-1:0] load_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              inst_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);
  logic [INST_W-1:0] imem [IMEM_DEPTH];
  state_e            state;
  logic [PC_W-1:0]   pc;
  logic              pend;
  logic [PC_W-1:0]   pend_pc;
  logic [INST_W-1:0] rdata;
  logic [1:0]        count;
  logic [INST_W-1:0] head_inst;
  logic [PC_W-1:0]   head_pc;
  logic              flush;
  logic              pop;
  logic              push;
  logic              halt_hit;
  logic              issue;
  logic [2:0]        occ;
  logic [PC_W-1:0]   new_pc;

  assign flush    = (state != IDLE) && (redirect_valid || (start && state == FETCH));
  assign new_pc   = redirect_valid ? redirect_pc : start_pc;
  assign pop      = inst_valid && inst_ready;
  assign push     = pend && !flush;
  assign halt_hit = (state == FETCH) && pend && (opcode_of(rdata) == HALT_OP);
  // Occupancy after this cycle's pop, so a draining queue can issue every cycle.
  assign occ      = 3'(count) - 3'(pop) + 3'(pend);
  assign issue    = (state == FETCH) && !flush && !halt_hit && (occ < 3'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= '0;
      pend   <= 1'b0;
      halted <= 1'b0;
    end else begin
      pend <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            pc    <= start_pc;
          end
        end
        FETCH: begin
          if (flush) begin
            pc <= new_pc;
          end else begin
            if (issue) pc <= pc + PC_W'(1);
            if (halt_hit) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        HALT: begin
          if (redirect_valid || start) begin
            state  <= FETCH;
            halted <= 1'b0;
            pc     <= new_pc;
          end
        end
        default: begin
          state  <= IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Synchronous read returns the pre-write word on a same-address collision.
  always_ff @(posedge clk) begin
    if (load_en) imem[load_addr] <= load_data;
    if (issue) begin
      rdata   <= imem[pc];
      pend_pc <= pc;
    end
  end

  fetch_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_inst (rdata),
    .push_pc   (pend_pc),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head_inst (head_inst),
    .head_pc   (head_pc)
  );

  assign inst_valid = (count != 2'd0);
  assign inst       = inst_valid ? head_inst : '0;
  assign inst_pc    = inst_valid ? head_pc : '0;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
    end else if (pop && (fetch_count != 32'hFFFF_FFFF)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif
endmodule
